instr_mem_fetch: RTL and testbench

Parametrised, clocked successor to the combinational instruction ROM. It holds a DEPTH-word instruction store that a loader port writes at run time, so program contents are no longer hard-wired. The fetch side uses a valid/ready request/response handshake with one-cycle read latency, backpressure and flush support. It also reports out-of-range and misaligned fetches and counts accepted fetches. It sits between the PC/fetch stage and the decoder.

---
 rtl/instr_mem_fetch.sv | 77 +++++++
 tb/tb_instr_mem_fetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_fetch.sv
// Run-time loadable instruction store with a valid/ready fetch port.
// One-cycle read latency, backpressure, flush, error flagging and fetch count.
module instr_mem_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 64,
  parameter logic [DATA_W-1:0] OOR_WORD = '0,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              prog_en,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [CNT_W-1:0]  fetch_cnt
);

  localparam logic [ADDR_W-2:0] LIMIT =
    (ADDR_W-1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-3:0] widx;
  logic [IDX_W-1:0]  idx;
  logic              misal;
  logic              oor;
  logic              err;
  logic              accept;

  assign widx  = req_addr[ADDR_W-1:2];
  assign idx   = req_addr[IDX_W+1:2];
  assign misal = |req_addr[1:0];
  assign oor   = {1'b0, widx} >= LIMIT;
  assign err   = misal | oor;

  assign req_ready = rst_n && !prog_en && !flush &&
                     (!rsp_valid || rsp_ready);
  assign accept = req_valid && req_ready;

  // Store is not reset so a program survives rst_n.
  always_ff @(posedge clk) begin
    if (prog_en) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_instr <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_instr <= err ? OOR_WORD : mem[idx];
      rsp_err   <= err;
    end else if (flush || rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
    end else if (accept && fetch_cnt != '1) begin
      fetch_cnt <= fetch_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Randomised bench for instr_mem_fetch with a behavioural fetch model
// and directed literal checks of the documented scenarios.
module tb_instr_mem_fetch;

  localparam logic [31:0] OOR = 32'hBADC_0DE5;
  localparam int CMAX = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_instr;
  logic        rsp_err;
  logic        flush = 1'b0;
  logic        prog_en = 1'b0;
  logic [5:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic [2:0]  fetch_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit run = 1'b0;

  instr_mem_fetch #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(64),
    .OOR_WORD(OOR), .CNT_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_err(rsp_err),
    .flush(flush), .prog_en(prog_en),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a word array plus the pending response.
  logic [31:0] m [64];
  bit          e_v = 0;
  logic [31:0] e_i = '0;
  bit          e_e = 0;
  int          e_c = 0;

  function automatic bit e_rdy();
    return rst_n && !prog_en && !flush && (!e_v || rsp_ready);
  endfunction

  always @(posedge clk) begin
    if (prog_en) m[prog_addr] = prog_data;
  end

  always @(posedge clk or negedge rst_n) begin
    bit bad;
    if (!rst_n) begin
      e_v = 0; e_i = '0; e_e = 0; e_c = 0;
    end else if (req_valid && e_rdy()) begin
      bad = (req_addr % 4 != 0) || (req_addr / 4 >= 64);
      e_i = bad ? OOR : m[(req_addr / 4) % 64];
      e_e = bad;
      e_v = 1;
      if (e_c < CMAX) e_c++;
    end else if (flush || rsp_ready) begin
      e_v = 0;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(e_v));
      chk("req_ready", 32'(req_ready), 32'(e_rdy()));
      chk("rsp_instr", rsp_instr, e_i);
      chk("rsp_err", 32'(rsp_err), 32'(e_e));
      chk("fetch_cnt", 32'(fetch_cnt), 32'(e_c));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)
      req_addr = ($urandom % 256) | 32'h1;
    else if (r == 1)
      req_addr = ($urandom | 32'h100) & ~32'h3;
    else
      req_addr = ($urandom % 64) << 2;
  endtask

  initial begin
    logic [31:0] prog0 [3];
    prog0[0] = 32'h0000_0013;
    prog0[1] = 32'h0000_10B7;
    prog0[2] = 32'h0000_A183;

    repeat (2) step();
    rst_n = 1'b1;
    run = 1'b1;
    chk("reset_cnt", 32'(fetch_cnt), 32'd0);
    chk("reset_valid", 32'(rsp_valid), 32'd0);

    for (int i = 0; i < 64; i++) begin
      prog_en = 1'b1;
      prog_addr = 6'(i);
      prog_data = (i < 3) ? prog0[i] : $urandom;
      step();
    end
    prog_en = 1'b0;

    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h0; step();
    chk("t1_w0", rsp_instr, 32'h0000_0013);
    chk("t1_v0", 32'(rsp_valid), 32'd1);
    req_addr = 32'h4; step();
    chk("t1_w1", rsp_instr, 32'h0000_10B7);
    req_addr = 32'h8; step();
    chk("t1_w2", rsp_instr, 32'h0000_A183);
    chk("t1_err", 32'(rsp_err), 32'd0);
    chk("t1_cnt", 32'(fetch_cnt), 32'd3);
    req_valid = 1'b0; step();

    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr = 32'h4; step();
    req_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_v", 32'(rsp_valid), 32'd1);
      chk("t2_hold_i", rsp_instr, 32'h0000_10B7);
      chk("t2_rdy", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1; #1;
    chk("t2_rdy_on", 32'(req_ready), 32'd1);
    step();
    chk("t2_next", rsp_instr, 32'h0000_A183);

    req_addr = 32'h6; step();
    chk("t3_mis_e", 32'(rsp_err), 32'd1);
    chk("t3_mis_i", rsp_instr, OOR);
    req_addr = 32'h100; step();
    chk("t3_oor_e", 32'(rsp_err), 32'd1);
    chk("t3_oor_i", rsp_instr, OOR);
    chk("t3_cnt", 32'(fetch_cnt), 32'd7);

    rsp_ready = 1'b0;
    req_addr = 32'h0; step();
    chk("t4_pend", 32'(rsp_valid), 32'd1);
    flush = 1'b1; #1;
    chk("t4_rdy", 32'(req_ready), 32'd0);
    step();
    chk("t4_flushed", 32'(rsp_valid), 32'd0);
    flush = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("t4_after", rsp_instr, 32'h0000_0013);

    prog_en = 1'b1;
    prog_addr = 6'd1;
    prog_data = 32'hDEAD_BEEF;
    req_addr = 32'h4; #1;
    chk("t5_rdy", 32'(req_ready), 32'd0);
    step();
    prog_en = 1'b0; #1;
    chk("t5_rdy2", 32'(req_ready), 32'd1);
    step();
    chk("t5_new", rsp_instr, 32'hDEAD_BEEF);

    req_addr = 32'h0;
    repeat (10) step();
    chk("t6_sat", 32'(fetch_cnt), 32'd7);
    rsp_ready = 1'b0; step();
    chk("t6_pend", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0; #1;
    chk("t6_rst_v", 32'(rsp_valid), 32'd0);
    chk("t6_rst_c", 32'(fetch_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    step();
    chk("t6_keep", rsp_instr, 32'h0000_0013);

    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom % 4) != 0;
      rsp_ready = ($urandom % 4) != 0;
      flush = ($urandom % 16) == 0;
      prog_en = ($urandom % 12) == 0;
      prog_addr = 6'($urandom);
      prog_data = $urandom;
      rand_addr();
      if (($urandom % 300) == 0) begin
        prog_en = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step();
    end

    req_valid = 1'b0;
    prog_en = 1'b0;
    flush = 1'b0;
    repeat (3) step();
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
